count_sequencer: RTL

//  Control stage directly upstream of the N-bit step counter. Accepts a job length,

---
 rtl/count_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : count_sequencer
// Description : Control stage for an external N-bit step counter. Accepts a
//               job length, presets the counter to ~len so that it reaches
//               all-ones after exactly len increments, enables it once per
//               datapath step, and ends the job on the counter's
//               terminal-count flag with a one-cycle done pulse. A watchdog
//               ends a job whose terminal count never arrives and raises a
//               sticky error flag.
// Optional    : define SEQ_PAUSE_EN to add the 'pause' input. While pause is
//               high in RUN, no step is issued, the state is held and the
//               watchdog is frozen.
// Ports       : clk       - clock, all state changes on the rising edge
//               clr_n     - synchronous active-low reset
//               pause     - (SEQ_PAUSE_EN only) stall stepping in RUN
//               start     - job request, sampled only while ready=1
//               len       - job step count, captured on an accepted start
//               ready     - idle, start can be accepted
//               busy      - job in progress (LOAD or RUN)
//               done      - one-cycle pulse at job end
//               err       - watchdog fired, sticky until next accepted start
//               cnt_init  - counter preset value (~len_q)
//               cnt_ld    - counter load strobe
//               cnt_en    - counter increment enable
//               cnt_ov    - counter terminal-count flag (all-ones)
//               step_en   - datapath step strobe, equal to cnt_en
//               first     - marks the first step of a job
// Revision    : 1.0 - initial release
// ============================================================================

module count_sequencer #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         clr_n,
`ifdef SEQ_PAUSE_EN
    input  logic         pause,
`endif
    input  logic         start,
    input  logic [N-1:0] len,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] cnt_init,
    output logic         cnt_ld,
    output logic         cnt_en,
    input  logic         cnt_ov,
    output logic         step_en,
    output logic         first
);

    // A healthy job spends at most 2^N RUN cycles (2^N-1 steps plus the
    // cycle that observes cnt_ov). The watchdog fires on the RUN cycle in
    // which its count would advance past 2^N.
    localparam logic [N:0] c_WDOG_LIMIT = {1'b1, {N{1'b0}}};
    localparam logic [N:0] c_WDOG_ONE   = {{N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_len_q;
    logic         r_err;
    logic [N:0]   r_wdog;
    logic         r_first_pend;

    state_t       w_state_nxt;
    logic [N-1:0] w_len_nxt;
    logic         w_err_nxt;
    logic [N:0]   w_wdog_nxt;
    logic         w_first_nxt;

    logic         w_ready;
    logic         w_busy;
    logic         w_done;
    logic         w_ld;
    logic         w_step;
    logic         w_first;
    logic         w_pause;

`ifdef SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state      <= S_IDLE;
            r_len_q      <= '0;
            r_err        <= 1'b0;
            r_wdog       <= '0;
            r_first_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len_q      <= w_len_nxt;
            r_err        <= w_err_nxt;
            r_wdog       <= w_wdog_nxt;
            r_first_pend <= w_first_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_q;
        w_err_nxt   = r_err;
        w_wdog_nxt  = r_wdog;
        w_first_nxt = r_first_pend;

        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_ld        = 1'b0;
        w_step      = 1'b0;
        w_first     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_err_nxt = 1'b0;
                    if (len != '0) begin
                        w_len_nxt   = len;
                        w_state_nxt = S_LOAD;
                    end else begin
                        // Zero-length job: nothing to count, finish at once.
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_LOAD: begin
                w_busy      = 1'b1;
                w_ld        = 1'b1;
                w_wdog_nxt  = '0;
                w_first_nxt = 1'b1;
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                w_busy = 1'b1;
                if (!w_pause) begin
                    w_step  = ~cnt_ov;
                    // 'first' waits for the first cycle that really steps,
                    // so a stalled first RUN cycle keeps it pending.
                    w_first = r_first_pend & ~cnt_ov;
                    if (!cnt_ov) begin
                        w_first_nxt = 1'b0;
                    end
                    if (cnt_ov) begin
                        w_state_nxt = S_DONE;
                    end else if (r_wdog == c_WDOG_LIMIT) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_wdog_nxt = r_wdog + c_WDOG_ONE;
                    end
                end
            end

            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready    = w_ready;
    assign busy     = w_busy;
    assign done     = w_done;
    assign err      = r_err;
    assign cnt_init = ~r_len_q;
    assign cnt_ld   = w_ld;
    assign cnt_en   = w_step;
    assign step_en  = w_step;
    assign first    = w_first;

`ifndef SYNTHESIS
    // Exactly one of idle / in-progress / finishing at any time.
    a_state_onehot: assert property (@(posedge clk) $onehot({ready, busy, done}));
    // The counter is only ever advanced while a job is in progress.
    a_step_in_job:  assert property (@(posedge clk) cnt_en |-> busy);
`endif

endmodule

`default_nettype wire
